// File: rtl/block_pixel_streamer.sv
// block_pixel_streamer: scans a grayscale frame from a synchronous pixel memory
// as non-overlapping MxM blocks in raster order. Each block goes out as a
// row-major pixel/ena burst, and the streamer waits for the sigma calculator's
// ready before it starts the next block. Partial edge blocks are skipped.
module block_pixel_streamer #(
    parameter int Data_Depth = 8,
    parameter int Img_Width  = 512,
    parameter int Img_Height = 512,
    parameter int Addr_Width = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [9:0]            m_i,
    output logic                  mem_rd_o,
    output logic [Addr_Width-1:0] mem_addr_o,
    input  logic [Data_Depth-1:0] mem_data_i,
    output logic [Data_Depth-1:0] pixel_o,
    output logic                  ena_o,
    input  logic                  sigma_ready_i,
    output logic [9:0]            block_x_o,
    output logic [9:0]            block_y_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int MinDim = (Img_Width < Img_Height) ? Img_Width : Img_Height;
    // Wide enough for (block origin + 2*M), which is used to spot the last block.
    localparam int PosW   = $clog2(Img_Width + Img_Height) + 2;

    localparam logic [Addr_Width-1:0] RowPitch = Addr_Width'(Img_Width);
    localparam logic [PosW-1:0]       ImgW     = PosW'(Img_Width);
    localparam logic [PosW-1:0]       ImgH     = PosW'(Img_Height);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [9:0]              m_q;
    logic [19:0]             mm_q;          // M*M pixels per block
    logic [19:0]             pix_cnt_q;     // reads issued in the current block
    logic [9:0]              col_q;         // column within the block
    logic [PosW-1:0]         x0_q;          // pixel column of the block origin
    logic [PosW-1:0]         y0_q;          // pixel row of the block origin
    logic [9:0]              bx_q;
    logic [9:0]              by_q;
    logic [Addr_Width-1:0]   blk_base_q;    // address of the block's top-left pixel
    logic [Addr_Width-1:0]   row_base_q;    // address of column 0 of the current row
    logic [Addr_Width-1:0]   mem_addr_q;
    logic                    mem_rd_q;
    logic                    rd_dly_q;      // mem_data_i carries a requested pixel this cycle
    logic [Data_Depth-1:0]   pixel_q;
    logic                    ena_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic                    m_legal_d;
    logic [PosW-1:0]         m_ext_d;
    logic [Addr_Width-1:0]   row_next_d;
    logic [Addr_Width-1:0]   blk_next_d;
    logic                    last_pix_d;
    logic                    col_wrap_d;
    logic                    last_col_d;
    logic                    last_row_d;

    // Address stepping and block-grid decisions; all adders, no multiplier.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        m_legal_d  = (m_i != '0) && (int'(m_i) <= MinDim);
        m_ext_d    = PosW'(m_q);
        row_next_d = row_base_q + RowPitch;
        last_pix_d = (pix_cnt_q == mm_q - 20'd1);
        col_wrap_d = (col_q == m_q - 10'd1);
        // The block is the last in its row/column when another full block would not fit.
        last_col_d = (x0_q + (m_ext_d << 1)) > ImgW;
        last_row_d = (y0_q + (m_ext_d << 1)) > ImgH;
        // In WAIT, row_base_q already points M rows below the block origin.
        blk_next_d = blk_base_q + Addr_Width'(m_q);
        if (last_col_d) begin
            blk_next_d = row_base_q - Addr_Width'(x0_q);
        end
    end

    // Frame-scan FSM with registered read strobe, pixel pipeline and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            mm_q       <= '0;
            pix_cnt_q  <= '0;
            col_q      <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            blk_base_q <= '0;
            row_base_q <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            rd_dly_q   <= 1'b0;
            pixel_q    <= '0;
            ena_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rd_dly_q <= mem_rd_q;
            if (rd_dly_q) begin
                pixel_q <= mem_data_i;
            end
            // ena follows the returning data and is held through WAIT until ready.
            ena_q <= rd_dly_q | (ena_q & (state_q == S_WAIT) & ~sigma_ready_i);

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (m_legal_d) begin
                            m_q        <= m_i;
                            mm_q       <= 20'(m_i) * 20'(m_i);
                            pix_cnt_q  <= '0;
                            col_q      <= '0;
                            x0_q       <= '0;
                            y0_q       <= '0;
                            bx_q       <= '0;
                            by_q       <= '0;
                            blk_base_q <= '0;
                            row_base_q <= '0;
                            mem_addr_q <= '0;
                            mem_rd_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            err_q      <= 1'b0;
                            state_q    <= S_STREAM;
                        end else begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end

                S_STREAM: begin
                    if (col_wrap_d) begin
                        col_q      <= '0;
                        row_base_q <= row_next_d;
                    end else begin
                        col_q <= col_q + 10'd1;
                    end
                    if (last_pix_d) begin
                        pix_cnt_q <= '0;
                        mem_rd_q  <= 1'b0;
                        state_q   <= S_WAIT;
                    end else begin
                        pix_cnt_q  <= pix_cnt_q + 20'd1;
                        mem_addr_q <= col_wrap_d ? row_next_d : mem_addr_q + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (sigma_ready_i) begin
                        if (last_col_d && last_row_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            if (last_col_d) begin
                                bx_q <= '0;
                                x0_q <= '0;
                                by_q <= by_q + 10'd1;
                                y0_q <= y0_q + m_ext_d;
                            end else begin
                                bx_q <= bx_q + 10'd1;
                                x0_q <= x0_q + m_ext_d;
                            end
                            blk_base_q <= blk_next_d;
                            row_base_q <= blk_next_d;
                            mem_addr_q <= blk_next_d;
                            col_q      <= '0;
                            mem_rd_q   <= 1'b1;
                            state_q    <= S_STREAM;
                        end
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = mem_addr_q;
    assign pixel_o    = pixel_q;
    assign ena_o      = ena_q;
    assign block_x_o  = bx_q;
    assign block_y_o  = by_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_block_pixel_streamer.sv
// Bench for block_pixel_streamer on an 8x8 image whose memory holds mem[a] = a.
// Expected reads and pixels are queued when a frame is started and popped
// as the design produces them.
module tb_block_pixel_streamer;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [9:0]    m_in = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] pixel;
    logic          ena;
    logic          sigma_ready = 1'b0;
    logic [9:0]    block_x;
    logic [9:0]    block_y;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    block_pixel_streamer #(
        .Data_Depth(DW),
        .Img_Width (W),
        .Img_Height(H),
        .Addr_Width(AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .m_i          (m_in),
        .mem_rd_o     (mem_rd),
        .mem_addr_o   (mem_addr),
        .mem_data_i   (mem_data),
        .pixel_o      (pixel),
        .ena_o        (ena),
        .sigma_ready_i(sigma_ready),
        .block_x_o    (block_x),
        .block_y_o    (block_y),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    // Synchronous pixel memory: data is the address itself, one cycle after the read.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= DW'(mem_addr);
    end

    typedef struct {
        int bx;
        int by;
        int val;
    } pix_t;

    pix_t pix_q[$];
    int   addr_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pix_seen = 0;
    int   cur_mm   = 0;
    int   burst    = 0;
    int   done_cnt = 0;
    pix_t p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: every read address and every fresh pixel of a burst.
    always @(negedge clk) begin
        if (rst) begin
            burst = 0;
        end else begin
            if (mem_rd) begin
                if (addr_q.size() == 0) check("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
                else check("mem_addr", 32'(mem_addr), addr_q.pop_front());
            end
            if (ena) begin
                burst++;
                if (burst <= cur_mm) begin
                    if (pix_q.size() == 0) begin
                        check("unexpected_pixel", 32'(pixel), 32'hFFFF_FFFF);
                    end else begin
                        p = pix_q.pop_front();
                        check("pixel", 32'(pixel), p.val);
                        check("block_x", 32'(block_x), p.bx);
                        check("block_y", 32'(block_y), p.by);
                    end
                    pix_seen++;
                end
            end else begin
                burst = 0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic wait_pixels(input int target, output bit ok);
        int budget = 2000;
        while (pix_seen < target && budget > 0) begin
            step();
            budget--;
        end
        ok = (pix_seen >= target);
        if (!ok) check("pixel_timeout", pix_seen, target);
    endtask

    // Runs one frame; rst_px >= 0 resets the design at that pixel of block 1.
    task automatic run_frame(input int m, input int stall0, input int rst_px);
        int nbx = W / m;
        int nby = H / m;
        int mm  = m * m;
        int nb  = nbx * nby;
        bit ok;
        for (int by = 0; by < nby; by++)
            for (int bx = 0; bx < nbx; bx++)
                for (int r = 0; r < m; r++)
                    for (int c = 0; c < m; c++) begin
                        int a = (by * m + r) * W + bx * m + c;
                        addr_q.push_back(a);
                        pix_q.push_back('{bx: bx, by: by, val: a % 256});
                    end
        cur_mm   = mm;
        pix_seen = 0;
        done_cnt = 0;

        m_in  = 10'(m);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_mem_rd", mem_rd, 1);
        check("start_mem_addr", 32'(mem_addr), 0);
        check("start_busy", busy, 1);
        check("start_err_cleared", err, 0);
        step();
        check("lat_ena_c2", ena, 0);
        step();
        check("lat_ena_c3", ena, 1);
        check("lat_pixel_c3", 32'(pixel), 0);

        for (int blk = 0; blk < nb; blk++) begin
            if (rst_px >= 0 && blk == 1) begin
                wait_pixels(mm + rst_px + 1, ok);
                rst = 1'b1;
                step();
                check("rst_ena", ena, 0);
                check("rst_mem_rd", mem_rd, 0);
                check("rst_busy", busy, 0);
                check("rst_block_x", 32'(block_x), 0);
                rst = 1'b0;
                addr_q.delete();
                pix_q.delete();
                return;
            end
            wait_pixels((blk + 1) * mm, ok);
            if (!ok) return;
            if (blk == 0 && stall0 > 0) begin
                for (int i = 0; i < stall0; i++) begin
                    check("stall_ena", ena, 1);
                    check("stall_mem_rd", mem_rd, 0);
                    check("stall_pixel", 32'(pixel), (m - 1) * W + m - 1);
                    check("stall_busy", busy, 1);
                    start = (i == 2);   // must be ignored while busy
                    m_in  = (i == 2) ? 10'd2 : 10'(m);
                    step();
                end
                start = 1'b0;
                m_in  = 10'(m);
            end
            sigma_ready = 1'b1;
            step();
            sigma_ready = 1'b0;
            if (blk == nb - 1) begin
                check("end_done", done, 1);
                check("end_busy", busy, 0);
                check("end_ena", ena, 0);
                check("end_mem_rd", mem_rd, 0);
                step();
                check("end_done_clear", done, 0);
            end else begin
                int nbxi = (blk + 1) % nbx;
                int nbyi = (blk + 1) / nbx;
                check("gap_ena1", ena, 0);
                check("gap_mem_rd", mem_rd, 1);
                check("gap_first_addr", 32'(mem_addr), nbyi * m * W + nbxi * m);
                check("gap_block_x", 32'(block_x), nbxi);
                check("gap_block_y", 32'(block_y), nbyi);
                step();
                check("gap_ena2", ena, 0);
                step();
                check("gap_ena3", ena, 1);
            end
        end
        check("frame_done_pulses", done_cnt, 1);
        check("reads_left", addr_q.size(), 0);
        check("pixels_left", pix_q.size(), 0);
    endtask

    task automatic run_illegal(input int m);
        m_in  = 10'(m);
        start = 1'b1;
        step();
        start = 1'b0;
        check("ill_err", err, 1);
        check("ill_done", done, 1);
        check("ill_busy", busy, 0);
        check("ill_mem_rd", mem_rd, 0);
        step();
        check("ill_done_clear", done, 0);
        check("ill_err_held", err, 1);
        check("ill_busy_after", busy, 0);
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_state_mem_rd", mem_rd, 0);
        check("rst_state_mem_addr", 32'(mem_addr), 0);
        check("rst_state_pixel", 32'(pixel), 0);
        check("rst_state_ena", ena, 0);
        check("rst_state_block_x", 32'(block_x), 0);
        check("rst_state_block_y", 32'(block_y), 0);
        check("rst_state_busy", busy, 0);
        check("rst_state_done", done, 0);
        check("rst_state_err", err, 0);

        run_frame(4, 10, -1);
        repeat (3) step();
        run_frame(3, 0, -1);
        repeat (3) step();
        run_illegal(0);
        repeat (2) step();
        run_illegal(9);
        repeat (2) step();
        run_frame(4, 0, 5);
        repeat (3) step();
        run_frame(4, 0, -1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
